bin_to_bcd_seq: RTL and testbench

Parametrised, multi-cycle binary-to-BCD converter. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, with a start/done handshake. It replaces the fixed 4-bit combinational tens/ones splitter in the display path and feeds the per-digit seven-segment decoders for operands of arbitrary width. It adds an overflow/saturation mode for when the digit count is too small for the input range.

---
 rtl/bin_to_bcd_seq.sv | 135 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq
//  Purpose  : Multi-cycle binary-to-BCD converter (shift-and-add-3, one
//             operand bit per clock) with a start/done handshake.
//             If the number of digits is too small, the result saturates
//             to all nines and ovf is flagged.
//  Ports    : clk      - rising-edge clock
//             rst_n    - asynchronous active-low reset
//             start_i  - conversion request, sampled only while idle
//             bin_i    - unsigned operand, captured on the accepted start
//             ready_o  - idle; a start is accepted this cycle
//             busy_o   - conversion in progress
//             done_o   - one-cycle pulse; bcd_o/ovf_o freshly updated
//             bcd_o    - result, digit i in bits [4i+3:4i], digit 0 = ones
//             ovf_o    - operand exceeded 10^DIGITS-1 (bcd_o saturated)
//  Revision : 1.0  initial release
// ============================================================================
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [BIN_W-1:0]      bin_i,
   output logic                  ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  ovf_o
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [ACC_W-1:0] SAT_NINES = {DIGITS{4'h9}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   sr_q,    sr_d;
   logic [ACC_W-1:0]   acc_q,   acc_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               sovf_q,  sovf_d;
   logic               done_q,  done_d;
   logic [ACC_W-1:0]   bcd_q,   bcd_d;
   logic               ovf_q,   ovf_d;

   logic [ACC_W-1:0]   acc_adj;
   logic [ACC_W-1:0]   acc_shl;
   logic [BIN_W-1:0]   sr_shl;
   logic               sovf_shl;

   // Per-digit add-3 correction; each digit is a self-contained 4-bit add.
   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_adj
         assign acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ?
                                    (acc_q[4*i +: 4] + 4'd3) : acc_q[4*i +: 4];
      end
   endgenerate

   // {acc, sr} shifted left by one; the bit falling off the top of acc
   // means the value no longer fits in DIGITS digits.
   assign acc_shl  = {acc_adj[ACC_W-2:0], sr_q[BIN_W-1]};
   assign sr_shl   = sr_q << 1;
   assign sovf_shl = sovf_q | acc_adj[ACC_W-1];

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sovf_d  = sovf_q;
      done_d  = 1'b0;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               sr_d    = bin_i;
               acc_d   = '0;
               sovf_d  = 1'b0;
               cnt_d   = CNT_W'(BIN_W);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sr_d   = sr_shl;
            acc_d  = acc_shl;
            sovf_d = sovf_shl;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               bcd_d   = sovf_shl ? SAT_NINES : acc_shl;
               ovf_d   = sovf_shl;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         sovf_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sovf_q  <= sovf_d;
         done_q  <= done_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ready_o = (state_q == ST_IDLE);
   assign busy_o  = (state_q == ST_SHIFT);
   assign done_o  = done_q;
   assign bcd_o   = bcd_q;
   assign ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd_seq
//  Purpose  : Self-checking bench for bin_to_bcd_seq. Four instances cover
//             8b/3d, 4b/2d, 8b/2d (saturating) and 16b/5d configurations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bin_to_bcd_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  st;
   logic [7:0]  bn0, bn2;
   logic [3:0]  bn1;
   logic [15:0] bn3;

   logic rdy0, rdy1, rdy2, rdy3, bsy0, bsy1, bsy2, bsy3;
   logic dn0, dn1, dn2, dn3, ov0, ov1, ov2, ov3;
   logic [11:0] bcd0;
   logic [7:0]  bcd1, bcd2;
   logic [19:0] bcd3;

   logic [3:0]  rdy, bsy, dn, ov;
   logic [19:0] bcdv [4];
   assign rdy = {rdy3, rdy2, rdy1, rdy0};
   assign bsy = {bsy3, bsy2, bsy1, bsy0};
   assign dn  = {dn3, dn2, dn1, dn0};
   assign ov  = {ov3, ov2, ov1, ov0};
   assign bcdv[0] = {8'h00, bcd0};
   assign bcdv[1] = {12'h000, bcd1};
   assign bcdv[2] = {12'h000, bcd2};
   assign bcdv[3] = bcd3;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
      .clk(clk), .rst_n(rst_n), .start_i(st[0]), .bin_i(bn0),
      .ready_o(rdy0), .busy_o(bsy0), .done_o(dn0), .bcd_o(bcd0), .ovf_o(ov0));
   bin_to_bcd_seq #(.BIN_W(4), .DIGITS(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start_i(st[1]), .bin_i(bn1),
      .ready_o(rdy1), .busy_o(bsy1), .done_o(dn1), .bcd_o(bcd1), .ovf_o(ov1));
   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_c (
      .clk(clk), .rst_n(rst_n), .start_i(st[2]), .bin_i(bn2),
      .ready_o(rdy2), .busy_o(bsy2), .done_o(dn2), .bcd_o(bcd2), .ovf_o(ov2));
   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_d (
      .clk(clk), .rst_n(rst_n), .start_i(st[3]), .bin_i(bn3),
      .ready_o(rdy3), .busy_o(bsy3), .done_o(dn3), .bcd_o(bcd3), .ovf_o(ov3));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [19:0] bcd;
      logic        ovf;
      int          ecyc;
   } exp_t;

   typedef struct {
      int          d;
      logic [15:0] bin;
      logic [19:0] bcd;
      logic        ovf;
   } vec_t;

   exp_t q0[$], q1[$], q2[$], q3[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int wof(input int d);
      case (d)
         0: return 8;
         1: return 4;
         2: return 8;
         default: return 16;
      endcase
   endfunction

   function automatic int dof(input int d);
      case (d)
         0: return 3;
         1: return 2;
         2: return 2;
         default: return 5;
      endcase
   endfunction

   function automatic int qsize(input int d);
      case (d)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   task automatic qpush(input int d, input exp_t x);
      case (d)
         0: q0.push_back(x);
         1: q1.push_back(x);
         2: q2.push_back(x);
         default: q3.push_back(x);
      endcase
   endtask

   task automatic qpop(input int d, output exp_t x);
      case (d)
         0: x = q0.pop_front();
         1: x = q1.pop_front();
         2: x = q2.pop_front();
         default: x = q3.pop_front();
      endcase
   endtask

   task automatic qclear(input int d);
      case (d)
         0: q0.delete();
         1: q1.delete();
         2: q2.delete();
         default: q3.delete();
      endcase
   endtask

   // Reference: decimal digits by division, saturating to all nines.
   function automatic logic [19:0] bcd_ref(input int v, input int dg);
      logic [19:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < dg; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      if (x != 0)
         for (int i = 0; i < dg; i++) r[4*i +: 4] = 4'h9;
      return r;
   endfunction

   task automatic drive(input int d, input logic s, input logic [15:0] b);
      st[d] = s;
      case (d)
         0: bn0 = b[7:0];
         1: bn1 = b[3:0];
         2: bn2 = b[7:0];
         default: bn3 = b;
      endcase
   endtask

   task automatic wait_drain(input int d);
      int t;
      t = 0;
      while (qsize(d) != 0 && t < 60) begin
         @(negedge clk);
         t++;
      end
      if (qsize(d) != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: dut%0d result still pending, got none expected done", d);
         qclear(d);
      end
   endtask

   // One conversion: start on a single cycle, expectation queued at accept.
   task automatic run(input int d, input logic [15:0] b, input logic [19:0] e, input logic eo);
      exp_t x;
      @(negedge clk);
      chk("ready_before_start", 32'(rdy[d]), 32'd1);
      drive(d, 1'b1, b);
      @(posedge clk);
      #1;
      x.bcd  = e;
      x.ovf  = eo;
      x.ecyc = cyc + wof(d);
      qpush(d, x);
      @(negedge clk);
      drive(d, 1'b0, b);
      wait_drain(d);
   endtask

   // Output monitor: every done pulse is matched against the scoreboard.
   logic [3:0] pdn;
   int         bc [4];
   initial begin
      exp_t x;
      int   bad_dig;
      pdn = '0;
      for (int d = 0; d < 4; d++) bc[d] = 0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            if (!rst_n) begin
               bc[d]  = 0;
               pdn[d] = 1'b0;
            end else begin
               if (bsy[d]) bc[d]++;
               if (dn[d]) begin
                  chk("single_cycle_done", 32'(pdn[d]), 32'd0);
                  if (qsize(d) == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL unexpected_done: dut%0d got done expected none", d);
                  end else begin
                     qpop(d, x);
                     chk("bcd", 32'(bcdv[d]), 32'(x.bcd));
                     chk("ovf", 32'(ov[d]), 32'(x.ovf));
                     chk("latency", 32'(cyc), 32'(x.ecyc));
                     chk("busy_cycles", 32'(bc[d]), 32'(wof(d)));
                     chk("ready_in_done", 32'(rdy[d]), 32'd1);
                     bad_dig = 0;
                     for (int i = 0; i < dof(d); i++)
                        if (bcdv[d][4*i +: 4] > 4'd9) bad_dig++;
                     chk("digits_le9", 32'(bad_dig), 32'd0);
                  end
                  bc[d] = 0;
               end
               pdn[d] = dn[d];
            end
         end
      end
   end

   initial begin
      vec_t  vt[$];
      vec_t  v;
      exp_t  x;
      int    t;
      int    r;

      rst_n = 1'b0;
      st    = '0;
      bn0   = '0;
      bn1   = '0;
      bn2   = '0;
      bn3   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 32'(rdy), 32'hF);
      chk("reset_busy", 32'(bsy), 32'h0);
      chk("reset_done", 32'(dn), 32'h0);
      chk("reset_ovf", 32'(ov), 32'h0);
      chk("reset_bcd0", 32'(bcdv[0]), 32'h0);
      chk("reset_bcd3", 32'(bcdv[3]), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors.
      vt.push_back('{0, 16'd255,   20'h00255, 1'b0});
      vt.push_back('{0, 16'd0,     20'h00000, 1'b0});
      vt.push_back('{0, 16'd100,   20'h00100, 1'b0});
      vt.push_back('{2, 16'd200,   20'h00099, 1'b1});
      vt.push_back('{2, 16'd99,    20'h00099, 1'b0});
      vt.push_back('{2, 16'd100,   20'h00099, 1'b1});
      vt.push_back('{2, 16'd255,   20'h00099, 1'b1});
      vt.push_back('{3, 16'd65535, 20'h65535, 1'b0});
      vt.push_back('{3, 16'd0,     20'h00000, 1'b0});
      vt.push_back('{3, 16'd10000, 20'h10000, 1'b0});
      for (int k = 0; k < 16; k++)
         vt.push_back('{1, 16'(k), 20'(((k / 10) << 4) | (k % 10)), 1'b0});
      for (int i = 0; i < vt.size(); i++) begin
         v = vt[i];
         run(v.d, v.bin, v.bcd, v.ovf);
      end

      // Handshake: start during busy ignored, bin wiggle ignored,
      // start in the done cycle accepted back-to-back.
      @(negedge clk);
      drive(0, 1'b1, 16'd37);
      @(posedge clk);
      #1;
      x.bcd = 20'h00037; x.ovf = 1'b0; x.ecyc = cyc + 8;
      qpush(0, x);
      @(negedge clk);
      drive(0, 1'b0, 16'd37);
      @(negedge clk);
      chk("busy_mid_conv", 32'(bsy[0]), 32'd1);
      drive(0, 1'b1, 16'd250);
      @(negedge clk);
      drive(0, 1'b0, 16'd250);
      t = 0;
      while (!dn[0] && t < 40) begin
         @(negedge clk);
         t++;
         if (!dn[0]) drive(0, 1'b0, 16'($urandom));
      end
      if (!dn[0]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: handshake got no done expected done");
      end
      chk("ready_b2b", 32'(rdy[0]), 32'd1);
      drive(0, 1'b1, 16'd250);
      x.bcd = 20'h00250; x.ovf = 1'b0; x.ecyc = cyc + 1 + 8;
      qpush(0, x);
      @(negedge clk);
      drive(0, 1'b0, 16'd250);
      t = 0;
      while (qsize(0) != 0 && t < 40) begin
         @(negedge clk);
         t++;
         drive(0, 1'b0, 16'($urandom));
      end
      wait_drain(0);

      // Reset in the fourth busy cycle aborts the conversion.
      @(negedge clk);
      drive(0, 1'b1, 16'd255);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 16'd255);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_bcd", 32'(bcdv[0]), 32'h0);
      chk("abort_ovf", 32'(ov[0]), 32'h0);
      chk("abort_ready", 32'(rdy[0]), 32'd1);
      chk("abort_busy", 32'(bsy[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      run(0, 16'd42, 20'h00042, 1'b0);

      // Random regression on the 16-bit instance.
      for (int n = 0; n < 1000; n++) begin
         r = int'($urandom_range(0, 65535));
         run(3, 16'(r), bcd_ref(r, 5), 1'b0);
      end

      repeat (30) @(negedge clk);
      chk("queues_drained", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
